// File: rtl/oam_dma_arbiter_pkg.sv
// Shared types and constants for the CPU bus / OAM DMA arbiter.
// The DMA state, the CPU read-return source and the fixed memory-map pages live here.
package oam_dma_arbiter_pkg;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_START,
    DMA_XFER
  } dma_state_t;

  typedef enum logic [1:0] {
    SRC_MEM,
    SRC_HI,
    SRC_REG,
    SRC_BLOCKED
  } bus_src_t;

  localparam logic [15:0] OAM_BASE  = 16'hFE00;
  localparam logic [7:0]  HI_PAGE   = 8'hFF;
  localparam logic [7:0]  ECHO_PAGE = 8'hE0;

  // Pages E0-FF mirror C0-DF, so the DMA reads the underlying WRAM instead.
  function automatic logic [7:0] fold_page(input logic [7:0] src);
    return (src >= ECHO_PAGE) ? (src - 8'h20) : src;
  endfunction

endpackage

// File: rtl/oam_dma_arbiter_bus_addr_decoder.sv
// Combinational CPU address decode: selects which port serves a CPU access.
// Page FF stays reachable during DMA; everything below it is blocked.
module oam_dma_arbiter_bus_addr_decoder
  import oam_dma_arbiter_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46
) (
  input  logic [15:0] cpu_addr,
  input  logic        dma_active,
  output bus_src_t    src
);

  always_comb begin
    src = SRC_MEM;
    if (cpu_addr == DMA_REG_ADDR) begin
      src = SRC_REG;
    end else if (cpu_addr[15:8] == HI_PAGE) begin
      src = SRC_HI;
    end else if (dma_active) begin
      src = SRC_BLOCKED;
    end
  end

endmodule

// File: rtl/oam_dma_arbiter.sv
// Shares the external CPU bus between the CPU and the OAM DMA engine.
// A write to the DMA source register copies OAM_LEN bytes from page XX into OAM.
module oam_dma_arbiter
  import oam_dma_arbiter_pkg::*;
#(
  parameter int          OAM_LEN      = 160,
  parameter int          START_DELAY  = 1,
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_re,
  input  logic        cpu_we,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  hi_addr,
  output logic [7:0]  hi_wdata,
  output logic        hi_re,
  output logic        hi_we,
  input  logic [7:0]  hi_rdata,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_we,
  output logic        dma_active
);

  localparam logic [7:0] LAST_IDX     = 8'(OAM_LEN - 1);
  localparam logic [1:0] DELAY_RELOAD = 2'(START_DELAY - 1);

  dma_state_t state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [1:0] delay_q, delay_d;
  logic [7:0] dma_src_q, dma_src_d;
  logic       pend_q, pend_d;
  logic [7:0] pend_idx_q, pend_idx_d;
  logic       rd_pend_q, rd_pend_d;
  bus_src_t   rd_src_q, rd_src_d;
  logic [7:0] reg_snap_q, reg_snap_d;
  logic [7:0] rdata_hold_q, rdata_hold_d;

  bus_src_t   src;
  logic       reg_wr;
  logic       cpu_rd_only;

  oam_dma_arbiter_bus_addr_decoder #(
    .DMA_REG_ADDR(DMA_REG_ADDR)
  ) u_dec (
    .cpu_addr  (cpu_addr),
    .dma_active(dma_active),
    .src       (src)
  );

  assign reg_wr      = cpu_we && (cpu_addr == DMA_REG_ADDR);
  assign cpu_rd_only = cpu_re && !cpu_we;

  // The trailing pending write keeps the bus only when no restart is underway.
  assign dma_active = (state_q == DMA_XFER) || (pend_q && (state_q == DMA_IDLE));

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    delay_d    = delay_q;
    pend_d     = 1'b0;
    pend_idx_d = pend_idx_q;
    dma_src_d  = dma_src_q;
    case (state_q)
      DMA_IDLE: begin
      end
      DMA_START: begin
        if (delay_q == 2'd0) begin
          state_d = DMA_XFER;
          count_d = 8'd0;
        end else begin
          delay_d = delay_q - 2'd1;
        end
      end
      DMA_XFER: begin
        pend_d     = 1'b1;
        pend_idx_d = count_q;
        if (count_q == LAST_IDX) begin
          state_d = DMA_IDLE;
          count_d = 8'd0;
        end else begin
          count_d = count_q + 8'd1;
        end
      end
      default: state_d = DMA_IDLE;
    endcase
    // A register write restarts from any state; the read in flight is discarded.
    if (reg_wr) begin
      dma_src_d = cpu_wdata;
      state_d   = DMA_START;
      count_d   = 8'd0;
      delay_d   = DELAY_RELOAD;
      pend_d    = 1'b0;
    end
  end

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    hi_addr   = cpu_addr[7:0];
    hi_wdata  = cpu_wdata;
    hi_re     = 1'b0;
    hi_we     = 1'b0;
    if (state_q == DMA_XFER) begin
      mem_addr = {fold_page(dma_src_q), count_q};
      mem_re   = 1'b1;
    end else if (src == SRC_MEM) begin
      mem_re = cpu_rd_only;
      mem_we = cpu_we;
    end
    if (src == SRC_HI) begin
      hi_re = cpu_rd_only;
      hi_we = cpu_we;
    end
  end

  assign oam_we    = pend_q;
  assign oam_addr  = pend_idx_q;
  assign oam_wdata = mem_rdata;

  always_comb begin
    cpu_rdata = rdata_hold_q;
    if (rd_pend_q) begin
      case (rd_src_q)
        SRC_MEM: cpu_rdata = mem_rdata;
        SRC_HI:  cpu_rdata = hi_rdata;
        SRC_REG: cpu_rdata = reg_snap_q;
        default: cpu_rdata = 8'hFF;
      endcase
    end
  end

  always_comb begin
    rd_pend_d    = cpu_re;
    rd_src_d     = rd_src_q;
    reg_snap_d   = reg_snap_q;
    rdata_hold_d = cpu_rdata;
    if (cpu_re) begin
      rd_src_d   = cpu_we ? SRC_BLOCKED : src;
      reg_snap_d = dma_src_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= DMA_IDLE;
      count_q      <= 8'd0;
      delay_q      <= 2'd0;
      dma_src_q    <= 8'hFF;
      pend_q       <= 1'b0;
      pend_idx_q   <= 8'd0;
      rd_pend_q    <= 1'b0;
      rd_src_q     <= SRC_BLOCKED;
      reg_snap_q   <= 8'hFF;
      rdata_hold_q <= 8'hFF;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      delay_q      <= delay_d;
      dma_src_q    <= dma_src_d;
      pend_q       <= pend_d;
      pend_idx_q   <= pend_idx_d;
      rd_pend_q    <= rd_pend_d;
      rd_src_q     <= rd_src_d;
      reg_snap_q   <= reg_snap_d;
      rdata_hold_q <= rdata_hold_d;
    end
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter with WRAM/IO models and scoreboard queues
// for CPU read returns and OAM writes.
module tb_oam_dma_arbiter;
  import oam_dma_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_re;
  logic        cpu_we;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  hi_addr;
  logic [7:0]  hi_wdata;
  logic        hi_re;
  logic        hi_we;
  logic [7:0]  hi_rdata = 8'h00;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_we;
  logic        dma_active;

  always #5 clk = ~clk;

  oam_dma_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_re(cpu_re), .cpu_we(cpu_we),
    .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata),
    .hi_addr(hi_addr), .hi_wdata(hi_wdata), .hi_re(hi_re), .hi_we(hi_we),
    .hi_rdata(hi_rdata),
    .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_we(oam_we),
    .dma_active(dma_active)
  );

  logic [7:0] mem [0:65535];

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (hi_re)  hi_rdata <= 8'h12;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [15:0] exp_oam [$];
  logic [7:0]  exp_rd [$];
  int   wr_count = 0;
  int   last_we_cyc = 0;
  int   fall_cyc = 0;
  int   fall_count = 0;
  logic prev_active = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // OAM write scoreboard and dma_active falling-edge tracker
  always @(negedge clk) begin
    logic [15:0] e;
    if (oam_we) begin
      wr_count++;
      last_we_cyc = cyc;
      checks++;
      assert (exp_oam.size() > 0) else begin
        errors++;
        $error("FAIL oam_unexpected: observed idx %0d data %0h expected none", oam_addr, oam_wdata);
      end
      if (exp_oam.size() > 0) begin
        e = exp_oam.pop_front();
        chk("oam_write", {16'h0, oam_addr, oam_wdata}, {16'h0, e});
      end
    end
    if (prev_active && !dma_active) begin
      fall_cyc = cyc;
      fall_count++;
    end
    prev_active = dma_active;
  end

  task automatic cpu_read(input logic [15:0] a, input logic [7:0] e, input string tag);
    logic [7:0] want;
    cpu_addr = a;
    cpu_re   = 1'b1;
    exp_rd.push_back(e);
    @(negedge clk);
    cpu_re = 1'b0;
    want = exp_rd.pop_front();
    chk(tag, {24'h0, cpu_rdata}, {24'h0, want});
    $display("cpu read  %h -> %h (want %h)", a, cpu_rdata, want);
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_we    = 1'b1;
    @(negedge clk);
    cpu_we = 1'b0;
    $display("cpu write %h <- %h", a, d);
  endtask

  task automatic push_page(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) exp_oam.push_back({8'(i), mem[base + 16'(i)]});
  endtask

  task automatic wait_done(input int n0, input string tag);
    int k = 0;
    while (fall_count == n0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk(tag, {31'h0, (k < 400)}, 32'h1);
  endtask

  int c0;
  int n0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[16'hC100 + 16'(i)] = 8'(i) ^ 8'h3C;
      mem[16'hC300 + 16'(i)] = 8'(i) ^ 8'hA5;
      mem[16'hD000 + 16'(i)] = 8'(i + 7);
    end
    mem[16'hC000] = 8'h5A;

    rst = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00; cpu_re = 1'b0; cpu_we = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dma_active", {31'h0, dma_active}, 32'h0);
    chk("rst_oam_we", {31'h0, oam_we}, 32'h0);
    chk("rst_mem_re", {31'h0, mem_re}, 32'h0);
    chk("rst_cpu_rdata", {24'h0, cpu_rdata}, 32'hFF);
    rst = 1'b1;
    @(negedge clk);

    cpu_read(16'hFF46, 8'hFF, "reg_reset_value");
    cpu_read(16'hC000, 8'h5A, "wram_read");
    cpu_read(16'hFF80, 8'h12, "hi_read_idle");

    // Full transfer from page C1 with CPU traffic during XFER
    n0 = fall_count; wr_count = 0;
    push_page(16'hC100, 160);
    c0 = cyc;
    cpu_write(16'hFF46, 8'hC1);
    chk("start_inactive", {31'h0, dma_active}, 32'h0);
    chk("start_no_re", {31'h0, mem_re}, 32'h0);
    @(negedge clk);
    chk("first_re", {31'h0, mem_re}, 32'h1);
    chk("first_addr", {16'h0, mem_addr}, 32'hC100);
    chk("xfer_active", {31'h0, dma_active}, 32'h1);
    cpu_addr = 16'hC000; cpu_wdata = 8'h77; cpu_we = 1'b1;
    #1 chk("blocked_no_mem_we", {31'h0, mem_we}, 32'h0);
    @(negedge clk); cpu_we = 1'b0;
    cpu_read(16'hC000, 8'hFF, "blocked_read");
    cpu_read(16'hFF80, 8'h12, "hi_read_xfer");
    cpu_addr = 16'hFF80; cpu_wdata = 8'h34; cpu_we = 1'b1;
    #1 chk("hi_we_xfer", {31'h0, hi_we}, 32'h1);
    chk("hi_addr_xfer", {24'h0, hi_addr}, 32'h80);
    @(negedge clk); cpu_we = 1'b0;
    cpu_read(16'hFF46, 8'hC1, "reg_read_back");
    cpu_addr = 16'hFF81; cpu_re = 1'b1; cpu_we = 1'b1; cpu_wdata = 8'h00;
    #1 chk("re_we_no_hi_re", {31'h0, hi_re}, 32'h0);
    @(negedge clk); cpu_re = 1'b0; cpu_we = 1'b0;
    chk("re_we_blocked", {24'h0, cpu_rdata}, 32'hFF);
    wait_done(n0, "xfer_done");
    chk("last_oam_we_cycle", 32'(last_we_cyc), 32'(c0 + 162));
    chk("dma_fall_cycle", 32'(fall_cyc), 32'(c0 + 163));
    chk("oam_write_count", 32'(wr_count), 32'd160);
    chk("oam_queue_empty", 32'(exp_oam.size()), 32'd0);
    $display("dma C1 done: %0d writes to %h..", wr_count, OAM_BASE);
    cpu_read(16'hC000, 8'h5A, "wram_intact");

    // Restart at count=80 with source D0
    wr_count = 0;
    push_page(16'hC100, 80);
    push_page(16'hD000, 160);
    c0 = cyc;
    cpu_write(16'hFF46, 8'hC1);
    while (cyc < c0 + 82) @(negedge clk);
    chk("trail_we", {31'h0, oam_we}, 32'h1);
    chk("trail_idx", {24'h0, oam_addr}, 32'd79);
    cpu_write(16'hFF46, 8'hD0);
    chk("restart_inactive", {31'h0, dma_active}, 32'h0);
    chk("restart_no_we", {31'h0, oam_we}, 32'h0);
    @(negedge clk);
    chk("restart_addr", {16'h0, mem_addr}, 32'hD000);
    chk("restart_re", {31'h0, mem_re}, 32'h1);
    n0 = fall_count;
    wait_done(n0, "restart_done");
    chk("restart_fall_cycle", 32'(fall_cyc), 32'(c0 + 82 + 163));
    chk("restart_write_count", 32'(wr_count), 32'd240);
    chk("restart_queue_empty", 32'(exp_oam.size()), 32'd0);
    $display("dma restart done: %0d writes", wr_count);

    // Echo page E3 folds to C3
    n0 = fall_count;
    push_page(16'hC300, 160);
    cpu_write(16'hFF46, 8'hE3);
    @(negedge clk);
    chk("echo_addr", {16'h0, mem_addr}, 32'hC300);
    wait_done(n0, "echo_done");
    chk("echo_queue_empty", 32'(exp_oam.size()), 32'd0);
    $display("dma E3 done");

    // Reset during transfer at count=40
    push_page(16'hC100, 40);
    c0 = cyc;
    cpu_write(16'hFF46, 8'hC1);
    while (cyc < c0 + 42) @(negedge clk);
    chk("pre_reset_idx", {24'h0, oam_addr}, 32'd39);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) rst = 1'b1;
      chk("abort_oam_we", {31'h0, oam_we}, 32'h0);
      chk("abort_mem_re", {31'h0, mem_re}, 32'h0);
      chk("abort_active", {31'h0, dma_active}, 32'h0);
    end
    cpu_read(16'hFF46, 8'hFF, "reg_after_reset");
    chk("abort_queue_empty", 32'(exp_oam.size()), 32'd0);
    $display("reset abort done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
